// File: rtl/cnn_accel_pkg.sv
// Shared definitions for the CNN accelerator weight path.
//   - wf_state_e : weight FIFO-to-bank loader FSM encoding (IDLE/POP/DRAIN/FIN)
//   - KK, TILE_WORDS : tile geometry for the default configuration
//   - clog2 : counter width helper (never returns less than 1 bit)
// No ports; imported by weight_tile_counter and weight_fifo_to_bank.
package cnn_accel_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPop   = 2'd1,
        StDrain = 2'd2,
        StFin   = 2'd3
    } wf_state_e;

    localparam int unsigned DefK       = 3;
    localparam int unsigned DefTn      = 8;
    localparam int unsigned DefTm      = 8;
    localparam int unsigned KK         = DefK * DefK;
    localparam int unsigned TILE_WORDS = DefTn * DefTm * KK;

    // Width needed to count 0..n-1, with a 1-bit floor so a size-1 dimension
    // still gets a legal (always-zero) counter.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/weight_tile_counter.sv
// Four-level nested tile counter, j innermost, then i, tm, tn outermost.
// Ports:
//   clk  in   clock
//   rst  in   synchronous active-high reset
//   clr  in   synchronous clear (returns all counters to 0)
//   en   in   advance by one position
//   j, i out  kernel column / row, 0..K-1
//   tm   out  output-map index, 0..Tm-1
//   tn   out  input-map index, 0..Tn-1
//   last out  all counters at their maximum (final word of the tile)
module weight_tile_counter
    import cnn_accel_pkg::*;
#(
    parameter int unsigned K  = 3,
    parameter int unsigned Tm = 8,
    parameter int unsigned Tn = 8,
    localparam int unsigned JW  = clog2(K),
    localparam int unsigned TmW = clog2(Tm),
    localparam int unsigned TnW = clog2(Tn)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           en,
    output logic [JW-1:0]  j,
    output logic [JW-1:0]  i,
    output logic [TmW-1:0] tm,
    output logic [TnW-1:0] tn,
    output logic           last
);

    logic [JW-1:0]  j_q, j_d, i_q, i_d;
    logic [TmW-1:0] tm_q, tm_d;
    logic [TnW-1:0] tn_q, tn_d;
    logic           j_max, i_max, tm_max, tn_max;

    always_comb begin
        j_max  = (j_q == JW'(K - 1));
        i_max  = (i_q == JW'(K - 1));
        tm_max = (tm_q == TmW'(Tm - 1));
        tn_max = (tn_q == TnW'(Tn - 1));
        j_d    = j_q;
        i_d    = i_q;
        tm_d   = tm_q;
        tn_d   = tn_q;
        if (en) begin
            j_d = j_max ? '0 : j_q + 1'b1;
            if (j_max) begin
                i_d = i_max ? '0 : i_q + 1'b1;
                if (i_max) begin
                    tm_d = tm_max ? '0 : tm_q + 1'b1;
                    if (tm_max) begin
                        tn_d = tn_max ? '0 : tn_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            j_q  <= '0;
            i_q  <= '0;
            tm_q <= '0;
            tn_q <= '0;
        end else begin
            j_q  <= j_d;
            i_q  <= i_d;
            tm_q <= tm_d;
            tn_q <= tn_d;
        end
    end

    assign j    = j_q;
    assign i    = i_q;
    assign tm   = tm_q;
    assign tn   = tn_q;
    assign last = j_max && i_max && tm_max && tn_max;

endmodule

// File: rtl/weight_fifo_to_bank.sv
// Weight FIFO consumer: on start, pops one Tn x Tm x K x K tile (tn outer, tm, i, j inner)
// and scatters each word into bank tm at address tn*K*K + i*K + j, one cycle after its pop.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           1-cycle pulse, accepted only when idle
//   done            1-cycle pulse the cycle after the last bank write
//   busy            high from the cycle after start through the done cycle
//   fifo_pop        FIFO read strobe (never asserted while fifo_empty)
//   fifo_empty      FIFO empty flag
//   data_from_fifo  FIFO read data, valid the cycle after fifo_pop
//   bank_wr_en      one-hot bank write enable (Tm bits)
//   bank_wr_addr    shared bank write address (holds when idle)
//   bank_wr_data    shared bank write data (holds when idle)
//   bank_sel        only with WEIGHT_BANK_PINGPONG_EN: half select, drives bank_wr_addr[AW-1]
// Build option: define WEIGHT_BANK_PINGPONG_EN for double-buffered banks; the address
// arithmetic must then fit in AW-1 bits.
module weight_fifo_to_bank
    import cnn_accel_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32,
    parameter int unsigned K  = 3,
    parameter int unsigned Tn = 8,
    parameter int unsigned Tm = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          done,
    output logic          busy,
    output logic          fifo_pop,
    input  logic          fifo_empty,
    input  logic [DW-1:0] data_from_fifo,
    output logic [Tm-1:0] bank_wr_en,
    output logic [AW-1:0] bank_wr_addr,
`ifdef WEIGHT_BANK_PINGPONG_EN
    output logic          bank_sel,
`endif
    output logic [DW-1:0] bank_wr_data
);

    localparam int unsigned JW  = clog2(K);
    localparam int unsigned TmW = clog2(Tm);
    localparam int unsigned TnW = clog2(Tn);
    localparam int unsigned KSq = K * K;

    wf_state_e      state_q, state_d;
    logic           cnt_clr, cnt_last;
    logic [JW-1:0]  cnt_j, cnt_i;
    logic [TmW-1:0] cnt_tm;
    logic [TnW-1:0] cnt_tn;
    logic [AW-1:0]  addr_calc;

    // Write pipeline: captured on the pop cycle, presented on the next one.
    logic           wr_valid_q;
    logic [TmW-1:0] wr_tm_q;
    logic [AW-1:0]  wr_addr_q;
    logic [DW-1:0]  data_hold_q;

    weight_tile_counter #(
        .K  (K),
        .Tm (Tm),
        .Tn (Tn)
    ) u_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (fifo_pop),
        .j    (cnt_j),
        .i    (cnt_i),
        .tm   (cnt_tm),
        .tn   (cnt_tn),
        .last (cnt_last)
    );

    always_comb begin
        addr_calc = AW'(cnt_tn) * AW'(KSq) + AW'(cnt_i) * AW'(K) + AW'(cnt_j);
    end

    always_comb begin
        state_d  = state_q;
        fifo_pop = (state_q == StPop) && !fifo_empty;
        cnt_clr  = (state_q == StIdle) && start;
        done     = (state_q == StFin);
        busy     = (state_q != StIdle);
        unique case (state_q)
            StIdle:  if (start) state_d = StPop;
            StPop:   if (fifo_pop && cnt_last) state_d = StDrain;
            StDrain: if (wr_valid_q) state_d = StFin;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            wr_valid_q  <= 1'b0;
            wr_tm_q     <= '0;
            wr_addr_q   <= '0;
            data_hold_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_valid_q <= fifo_pop;
            if (fifo_pop) begin
                wr_tm_q   <= cnt_tm;
                wr_addr_q <= addr_calc;
            end
            if (wr_valid_q) begin
                data_hold_q <= data_from_fifo;
            end
        end
    end

    always_comb begin
        bank_wr_en = '0;
        for (int unsigned b = 0; b < Tm; b++) begin
            if (wr_valid_q && (wr_tm_q == TmW'(b))) begin
                bank_wr_en[b] = 1'b1;
            end
        end
    end

    // FIFO data is only valid on the write cycle; the held copy keeps the bus stable after.
    assign bank_wr_data = wr_valid_q ? data_from_fifo : data_hold_q;

`ifdef WEIGHT_BANK_PINGPONG_EN
    logic bank_sel_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_sel_q <= 1'b0;
        end else if (state_q == StFin) begin
            bank_sel_q <= ~bank_sel_q;
        end
    end

    assign bank_sel     = bank_sel_q;
    assign bank_wr_addr = {bank_sel_q, wr_addr_q[AW-2:0]};
`else
    assign bank_wr_addr = wr_addr_q;
`endif

endmodule

// File: tb/tb_weight_fifo_to_bank.sv
module tb_weight_fifo_to_bank;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int K  = 3;
    localparam int TM = 2;
    localparam int TN = 2;
    localparam int WORDS = TN * TM * K * K;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          done, busy, fifo_pop, fifo_empty;
    logic [DW-1:0] data_from_fifo = '0;
    logic [TM-1:0] bank_wr_en;
    logic [AW-1:0] bank_wr_addr;
    logic [DW-1:0] bank_wr_data;

    logic          s_start = 1'b0;
    logic          s_done, s_busy, s_pop, s_empty;
    logic [DW-1:0] s_data = '0;
    logic [0:0]    s_en;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
`ifdef WEIGHT_BANK_PINGPONG_EN
    logic          bank_sel, s_bank_sel;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model
    logic [DW-1:0] mem [0:127];
    int  fifo_count = 0;
    int  rd_ptr = 0;
    bit  gap_mode = 1'b0;
    bit  clr_req = 1'b0;

    assign fifo_empty = (rd_ptr >= fifo_count) || (gap_mode && (cyc % 3 == 0));
    assign s_empty    = 1'b0;

    always @(posedge clk) begin
        if (clr_req) begin
            rd_ptr <= 0;
        end else if (fifo_pop) begin
            data_from_fifo <= mem[rd_ptr % 128];
            rd_ptr <= rd_ptr + 1;
        end
        if (s_pop) s_data <= 32'hABCD_0001;
    end

    // Monitor
    int pop_n = 0, wr_n = 0, done_n = 0, pop_empty_n = 0, done_cyc = 0;
    int pop_cyc [0:127];
    int wr_cyc  [0:127];
    logic [TM-1:0] wr_en   [0:127];
    logic [AW-1:0] wr_addr [0:127];
    logic [DW-1:0] wr_data [0:127];

    always @(negedge clk) begin
        if (clr_req) begin
            pop_n <= 0; wr_n <= 0; done_n <= 0; pop_empty_n <= 0;
        end else begin
            if (fifo_pop) begin
                pop_cyc[pop_n % 128] <= cyc;
                pop_n <= pop_n + 1;
                if (fifo_empty) pop_empty_n <= pop_empty_n + 1;
            end
            if (bank_wr_en != '0) begin
                wr_cyc[wr_n % 128]  <= cyc;
                wr_en[wr_n % 128]   <= bank_wr_en;
                wr_addr[wr_n % 128] <= bank_wr_addr;
                wr_data[wr_n % 128] <= bank_wr_data;
                wr_n <= wr_n + 1;
            end
            if (done) begin
                done_n   <= done_n + 1;
                done_cyc <= cyc;
            end
        end
    end

    weight_fifo_to_bank #(.AW(AW), .DW(DW), .K(K), .Tn(TN), .Tm(TM)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .done           (done),
        .busy           (busy),
        .fifo_pop       (fifo_pop),
        .fifo_empty     (fifo_empty),
        .data_from_fifo (data_from_fifo),
        .bank_wr_en     (bank_wr_en),
        .bank_wr_addr   (bank_wr_addr),
`ifdef WEIGHT_BANK_PINGPONG_EN
        .bank_sel       (bank_sel),
`endif
        .bank_wr_data   (bank_wr_data)
    );

    weight_fifo_to_bank #(.AW(AW), .DW(DW), .K(1), .Tn(1), .Tm(1)) dut_small (
        .clk            (clk),
        .rst            (rst),
        .start          (s_start),
        .done           (s_done),
        .busy           (s_busy),
        .fifo_pop       (s_pop),
        .fifo_empty     (s_empty),
        .data_from_fifo (s_data),
        .bank_wr_en     (s_en),
        .bank_wr_addr   (s_addr),
`ifdef WEIGHT_BANK_PINGPONG_EN
        .bank_sel       (s_bank_sel),
`endif
        .bank_wr_data   (s_wdata)
    );

    // Reference placement of FIFO word w within a tile
    function automatic logic [AW-1:0] exp_addr(input int w);
        int tn, i, j;
        tn = w / (TM * K * K);
        i  = (w / K) % K;
        j  = w % K;
        return AW'(tn * K * K + i * K + j);
    endfunction

    function automatic logic [TM-1:0] exp_en(input int w);
        logic [TM-1:0] e;
        e = '0;
        e[(w / (K * K)) % TM] = 1'b1;
        return e;
    endfunction

    task automatic clear_env(input int nwords);
        @(posedge clk); #1 clr_req = 1'b1;
        @(posedge clk); #1 clr_req = 1'b0;
        for (int w = 0; w < nwords; w++) mem[w] = DW'(w);
        fifo_count = nwords;
    endtask

    task automatic pulse_start();
        @(negedge clk); #1 start = 1'b1;
        @(negedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int target, input string name);
        int n;
        for (n = 0; n < 400 && done_n < target; n++) begin
            @(negedge clk); #1;
        end
        checks++;
        if (done_n < target) begin
            errors++;
            $display("FAIL %s timeout: done count %0d, required %0d", name, done_n, target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b required 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b required 0", busy); end
        checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL reset pop: got %b required 0", fifo_pop); end
        checks++; if (bank_wr_en !== '0) begin errors++; $display("FAIL reset en: got %b required 0", bank_wr_en); end
        checks++; if (bank_wr_addr !== '0) begin errors++; $display("FAIL reset addr: got %0h required 0", bank_wr_addr); end
        checks++; if (bank_wr_data !== '0) begin errors++; $display("FAIL reset data: got %0h required 0", bank_wr_data); end
        rst = 1'b0;
    endtask

    // Shared by the plain and gapped tile runs: verifies the full 36-word scatter.
    task automatic test_tile(input bit gaps, input string name);
        clear_env(WORDS);
        gap_mode = gaps;
        pulse_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy: got %b required 1", name, busy); end
        wait_done(1, name);
        repeat (3) @(negedge clk);
        #1;
        gap_mode = 1'b0;
        checks++; if (pop_n != WORDS) begin errors++; $display("FAIL %s pops: got %0d required %0d", name, pop_n, WORDS); end
        checks++; if (wr_n != WORDS) begin errors++; $display("FAIL %s writes: got %0d required %0d", name, wr_n, WORDS); end
        checks++; if (done_n != 1) begin errors++; $display("FAIL %s done count: got %0d required 1", name, done_n); end
        checks++; if (pop_empty_n != 0) begin errors++; $display("FAIL %s pop while empty: got %0d required 0", name, pop_empty_n); end
        for (int w = 0; w < WORDS && w < wr_n; w++) begin
            checks++;
            if (wr_en[w] !== exp_en(w) || wr_addr[w] !== exp_addr(w) || wr_data[w] !== DW'(w)
                || wr_cyc[w] != pop_cyc[w] + 1) begin
                errors++;
                $display("FAIL %s word %0d: got en=%b addr=%0d data=%0d lat=%0d required en=%b addr=%0d data=%0d lat=1",
                         name, w, wr_en[w], wr_addr[w], wr_data[w], wr_cyc[w] - pop_cyc[w],
                         exp_en(w), exp_addr(w), w);
            end
        end
        checks++;
        if (wr_en[10] !== 2'b10 || wr_addr[10] !== 32'd1) begin
            errors++; $display("FAIL %s word10: got en=%b addr=%0d required en=10 addr=1", name, wr_en[10], wr_addr[10]);
        end
        checks++;
        if (wr_en[35] !== 2'b10 || wr_addr[35] !== 32'd17) begin
            errors++; $display("FAIL %s word35: got en=%b addr=%0d required en=10 addr=17", name, wr_en[35], wr_addr[35]);
        end
        checks++;
        if (done_cyc != wr_cyc[35] + 1) begin
            errors++; $display("FAIL %s done latency: got %0d required 1", name, done_cyc - wr_cyc[35]);
        end
        checks++;
        if (busy !== 1'b0 || bank_wr_en !== '0 || bank_wr_addr !== 32'd17 || bank_wr_data !== 32'd35) begin
            errors++; $display("FAIL %s idle hold: got busy=%b en=%b addr=%0d data=%0d required 0 0 17 35",
                               name, busy, bank_wr_en, bank_wr_addr, bank_wr_data);
        end
        if (gaps) begin
            checks++;
            if (pop_cyc[35] - pop_cyc[0] < WORDS) begin
                errors++; $display("FAIL %s gap span: got %0d required >= %0d", name, pop_cyc[35] - pop_cyc[0], WORDS);
            end
        end
    endtask

    task automatic test_restart_ignored();
        int n;
        clear_env(2 * WORDS);
        pulse_start();
        for (n = 0; n < 100 && pop_n < 5; n++) begin @(negedge clk); #1; end
        start = 1'b1;
        @(negedge clk); #1 start = 1'b0;
        for (n = 0; n < 200 && done !== 1'b1; n++) begin @(negedge clk); #1; end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL restart done seen: got %b required 1", done); end
        start = 1'b1;
        @(negedge clk); #1 start = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        checks++; if (pop_n != WORDS) begin errors++; $display("FAIL restart pops: got %0d required %0d", pop_n, WORDS); end
        checks++; if (wr_n != WORDS) begin errors++; $display("FAIL restart writes: got %0d required %0d", wr_n, WORDS); end
        checks++; if (done_n != 1) begin errors++; $display("FAIL restart done count: got %0d required 1", done_n); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL restart busy: got %b required 0", busy); end
    endtask

    task automatic test_reset_mid_tile();
        int n;
        clear_env(WORDS);
        pulse_start();
        for (n = 0; n < 100 && wr_n < 20; n++) begin @(negedge clk); #1; end
        rst = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (bank_wr_en !== '0 || fifo_pop !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL midreset outputs: got en=%b pop=%b busy=%b done=%b required all 0",
                               bank_wr_en, fifo_pop, busy, done);
        end
        rst = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        checks++; if (done_n != 0) begin errors++; $display("FAIL midreset done: got %0d required 0", done_n); end
        checks++; if (wr_n != 20) begin errors++; $display("FAIL midreset writes: got %0d required 20", wr_n); end
        clear_env(WORDS);
        pulse_start();
        for (n = 0; n < 20 && wr_n < 1; n++) begin @(negedge clk); #1; end
        checks++;
        if (wr_n < 1 || wr_en[0] !== 2'b01 || wr_addr[0] !== '0 || wr_data[0] !== '0) begin
            errors++; $display("FAIL midreset restart first write: got n=%0d en=%b addr=%0d data=%0d required en=01 addr=0 data=0",
                               wr_n, wr_en[0], wr_addr[0], wr_data[0]);
        end
        wait_done(1, "midreset drain");
    endtask

`ifdef WEIGHT_BANK_PINGPONG_EN
    task automatic test_pingpong();
        clear_env(2 * WORDS);
        pulse_start();
        wait_done(1, "pingpong tile1");
        @(negedge clk); #1 start = 1'b1;
        checks++; if (bank_sel !== 1'b1) begin errors++; $display("FAIL pingpong sel1: got %b required 1", bank_sel); end
        @(negedge clk); #1 start = 1'b0;
        wait_done(2, "pingpong tile2");
        repeat (2) @(negedge clk);
        #1;
        checks++; if (wr_n != 2 * WORDS) begin errors++; $display("FAIL pingpong writes: got %0d required %0d", wr_n, 2 * WORDS); end
        for (int w = 0; w < 2 * WORDS && w < wr_n; w++) begin
            logic [AW-1:0] ea;
            ea = exp_addr(w % WORDS);
            ea[AW-1] = (w >= WORDS);
            checks++;
            if (wr_addr[w] !== ea || wr_data[w] !== DW'(w)) begin
                errors++; $display("FAIL pingpong word %0d: got addr=%0h data=%0d required addr=%0h data=%0d",
                                   w, wr_addr[w], wr_data[w], ea, w);
            end
        end
        checks++; if (bank_sel !== 1'b0) begin errors++; $display("FAIL pingpong sel2: got %b required 0", bank_sel); end
    endtask
`endif

    task automatic test_small_tile();
        int pops = 0, wrs = 0, dones = 0, pcyc = -100, wcyc = -100, dcyc = -100;
        logic [AW-1:0] a = '1;
        logic [DW-1:0] d = '0;
        logic [0:0] e = '0;
        @(negedge clk); #1 s_start = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk); #1;
            s_start = 1'b0;
            if (s_pop) begin pops++; pcyc = cyc; end
            if (s_en != '0) begin wrs++; wcyc = cyc; e = s_en; a = s_addr; d = s_wdata; end
            if (s_done) begin dones++; dcyc = cyc; end
        end
        checks++; if (pops != 1) begin errors++; $display("FAIL small pops: got %0d required 1", pops); end
        checks++; if (wrs != 1) begin errors++; $display("FAIL small writes: got %0d required 1", wrs); end
        checks++;
        if (e !== 1'b1 || a !== '0 || d !== 32'hABCD_0001) begin
            errors++; $display("FAIL small write: got en=%b addr=%0d data=%0h required en=1 addr=0 data=abcd0001", e, a, d);
        end
        checks++; if (wcyc != pcyc + 1) begin errors++; $display("FAIL small write latency: got %0d required 1", wcyc - pcyc); end
        checks++; if (dones != 1 || dcyc != pcyc + 2) begin
            errors++; $display("FAIL small done: got count=%0d latency=%0d required count=1 latency=2", dones, dcyc - pcyc);
        end
    endtask

    initial begin
        test_reset();
        test_tile(1'b0, "tile");
        test_tile(1'b1, "gaps");
        test_restart_ignored();
        test_reset_mid_tile();
`ifdef WEIGHT_BANK_PINGPONG_EN
        test_pingpong();
`endif
        test_small_tile();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
